// File: rtl/branch_resolver.sv
// branch_resolver: 3-state branch resolution unit driving an external 32-bit comparator.
// Optional `BRANCH_RESOLVER_SIGNED_EN selects two's-complement ordered compares.
module branch_resolver (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_offset,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  input  logic        cmp_eq,
  input  logic        cmp_gt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_taken,
  output logic [31:0] resp_target,
  output logic        resp_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_BEQ = 3'd0,
    OP_BNE = 3'd1,
    OP_BLT = 3'd2,
    OP_BGE = 3'd3,
    OP_BGT = 3'd4,
    OP_BLE = 3'd5,
    OP_JAL = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] pc;
    logic [31:0] off;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] cmp_a_q, cmp_a_d;
  logic [31:0] cmp_b_q, cmp_b_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic [31:0] target_q, target_d;

  logic        accept;
  logic        flip;
  logic [31:0] mask;
  logic        eq, gt, lt;
  logic        cond;
  logic        cond_ill;
  logic [31:0] cond_tgt;

  assign accept = (state_q == S_IDLE) & req_valid;

  // Flipping bit 31 of both operands maps signed order onto unsigned order.
`ifdef BRANCH_RESOLVER_SIGNED_EN
  always_comb begin
    unique case (op_e'(req_op))
      OP_BLT, OP_BGE,
      OP_BGT, OP_BLE: flip = 1'b1;
      default:        flip = 1'b0;
    endcase
  end
`else
  assign flip = 1'b0;
`endif

  assign mask = {flip, 31'd0};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_CMP;
      S_CMP:  state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_CMP:  ;
      S_RESP: resp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  always_comb begin
    req_d   = req_q;
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    if (accept) begin
      req_d.op  = op_e'(req_op);
      req_d.pc  = req_pc;
      req_d.off = req_offset;
      cmp_a_d   = req_a ^ mask;
      cmp_b_d   = req_b ^ mask;
    end
  end

  // EQ wins when the comparator reports both flags.
  assign eq = cmp_eq;
  assign gt = cmp_gt & ~cmp_eq;
  assign lt = ~cmp_eq & ~cmp_gt;

  always_comb begin
    cond     = 1'b0;
    cond_ill = 1'b0;
    unique case (req_q.op)
      OP_BEQ: cond = eq;
      OP_BNE: cond = ~eq;
      OP_BLT: cond = lt;
      OP_BGE: cond = ~lt;
      OP_BGT: cond = gt;
      OP_BLE: cond = ~gt;
      OP_JAL: cond = 1'b1;
      OP_RSV: cond_ill = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign cond_tgt = cond ? (req_q.pc + req_q.off)
                         : (req_q.pc + 32'd4);

  always_comb begin
    taken_d   = taken_q;
    illegal_d = illegal_q;
    target_d  = target_q;
    if (state_q == S_CMP) begin
      taken_d   = cond;
      illegal_d = cond_ill;
      target_d  = cond_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else begin
      req_q     <= req_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      target_q  <= target_d;
    end
  end

  assign cmp_a        = cmp_a_q;
  assign cmp_b        = cmp_b_q;
  assign resp_taken   = taken_q;
  assign resp_target  = target_q;
  assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed stimulus, cycle model and literal checks for branch_resolver.
// Honours `BRANCH_RESOLVER_SIGNED_EN for the expected compare semantics.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, req_pc, req_offset;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_eq, cmp_gt;
  logic        resp_valid, resp_ready, resp_taken, resp_illegal, busy;
  logic [31:0] resp_target;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_gt = (cmp_a > cmp_b);

  branch_resolver dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_pc(req_pc), .req_offset(req_offset),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_target(resp_target),
    .resp_illegal(resp_illegal), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Spec-level resolution: plain arithmetic compares.
  function automatic void resolve(
    input  logic [2:0]  op,
    input  logic [31:0] a, b, pc, off,
    output logic        t,
    output logic [31:0] tgt,
    output logic        ill,
    output logic [31:0] ca, cb);
    logic lt, gt;
`ifdef BRANCH_RESOLVER_SIGNED_EN
    logic ord;
    ord = (op >= 3'd2) && (op <= 3'd5);
    lt  = $signed(a) < $signed(b);
    gt  = $signed(a) > $signed(b);
    ca  = ord ? {~a[31], a[30:0]} : a;
    cb  = ord ? {~b[31], b[30:0]} : b;
`else
    lt  = a < b;
    gt  = a > b;
    ca  = a;
    cb  = b;
`endif
    ill = 1'b0;
    case (op)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd2: t = lt;
      3'd3: t = !lt;
      3'd4: t = gt;
      3'd5: t = !gt;
      3'd6: t = 1'b1;
      default: begin t = 1'b0; ill = 1'b1; end
    endcase
    tgt = t ? pc + off : pc + 32'd4;
  endfunction

  // Cycle model: in-flight flag plus age since accept.
  bit          m_ok = 0;
  bit          m_busy;
  int          m_age;
  logic        m_taken, m_ill, p_taken, p_ill;
  logic [31:0] m_tgt, p_tgt, m_ca, m_cb, p_ca, p_cb;

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk1("req_ready", req_ready, !m_busy);
        chk1("busy", busy, m_busy);
        chk1("resp_valid", resp_valid, m_busy && m_age == 1);
        chk1("resp_taken", resp_taken, m_taken);
        chk1("resp_illegal", resp_illegal, m_ill);
        chk("resp_target", resp_target, m_tgt);
        chk("cmp_a", cmp_a, m_ca);
        chk("cmp_b", cmp_b, m_cb);
      end
      if (reset) begin
        m_busy = 0; m_age = 0;
        m_taken = 0; m_ill = 0; m_tgt = '0;
        m_ca = '0; m_cb = '0;
        m_ok = 1;
      end else if (m_ok) begin
        if (!m_busy) begin
          if (req_valid) begin
            resolve(req_op, req_a, req_b, req_pc, req_offset,
                    p_taken, p_tgt, p_ill, p_ca, p_cb);
            m_ca = p_ca; m_cb = p_cb;
            m_busy = 1; m_age = 0;
          end
        end else if (m_age == 0) begin
          m_age = 1;
          m_taken = p_taken; m_tgt = p_tgt; m_ill = p_ill;
        end else if (resp_ready) begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, b, pc, off);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_pc = pc; req_offset = off;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int lat;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 2);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk1("req_ready_after", req_ready, 1'b1);
  endtask

  task automatic expect_resp(input string nm, input logic t,
                             input logic [31:0] tgt, input logic ill);
    chk1({nm, "_taken"}, resp_taken, t);
    chk({nm, "_target"}, resp_target, tgt);
    chk1({nm, "_illegal"}, resp_illegal, ill);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_pc = '0; req_offset = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_target", resp_target, 32'h0);
    chk("rst_cmp_a", cmp_a, 32'h0);
    chk("rst_cmp_b", cmp_b, 32'h0);
    @(posedge clk); #1;

    send(3'd2, 32'd15, 32'd19, 32'h100, 32'h20);
    wait_resp();
    expect_resp("blt", 1'b1, 32'h120, 1'b0);
    finish_resp();

    resp_ready = 1'b0;
    send(3'd0, 32'd19, 32'd19, 32'h200, 32'h10);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      expect_resp("beq_stall", 1'b1, 32'h210, 1'b0);
      req_valid = (i % 2 == 0);
      req_op = 3'd1; req_a = 32'd7 + i; req_b = 32'd3;
      req_pc = 32'h900; req_offset = 32'h4;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    expect_resp("beq_hold", 1'b1, 32'h210, 1'b0);
    finish_resp();

    send(3'd4, 32'd15, 32'd19, 32'hFFFF_FFFC, 32'd8);
    wait_resp();
    expect_resp("bgt_wrap", 1'b0, 32'h0, 1'b0);
    finish_resp();

    send(3'd7, 32'd1, 32'd2, 32'h300, 32'h40);
    wait_resp();
    expect_resp("rsv", 1'b0, 32'h304, 1'b1);
    finish_resp();

    send(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h40);
    wait_resp();
`ifdef BRANCH_RESOLVER_SIGNED_EN
    expect_resp("blt_sgn", 1'b1, 32'h540, 1'b0);
    chk("sgn_cmp_a", cmp_a, 32'h7FFF_FFFF);
    chk("sgn_cmp_b", cmp_b, 32'h8000_0001);
`else
    expect_resp("blt_uns", 1'b0, 32'h504, 1'b0);
    chk("uns_cmp_a", cmp_a, 32'hFFFF_FFFF);
    chk("uns_cmp_b", cmp_b, 32'h0000_0001);
`endif
    finish_resp();

    send(3'd1, 32'd5, 32'd5, 32'h600, 32'h10);
    wait_resp();
    expect_resp("bne_eq", 1'b0, 32'h604, 1'b0);
    finish_resp();

    send(3'd3, 32'd19, 32'd15, 32'h700, 32'h10);
    wait_resp();
    expect_resp("bge", 1'b1, 32'h710, 1'b0);
    finish_resp();

    send(3'd5, 32'd19, 32'd19, 32'h800, 32'hFFFF_FFF0);
    wait_resp();
    expect_resp("ble_eq", 1'b1, 32'h7F0, 1'b0);
    finish_resp();

    send(3'd6, 32'd0, 32'd9, 32'hA00, 32'h100);
    wait_resp();
    expect_resp("jal", 1'b1, 32'hB00, 1'b0);
    finish_resp();

    send(3'd1, 32'd1, 32'd2, 32'hC00, 32'h8);
    chk1("in_cmp_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("no_resp_after_rst", resp_valid, 1'b0);
      @(posedge clk); #1;
    end
    send(3'd1, 32'd15, 32'd19, 32'h40, 32'h8);
    wait_resp();
    expect_resp("bne_post_rst", 1'b1, 32'h48, 1'b0);
    finish_resp();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
